// File: rtl/pulse_count_rx_if.sv
// Link and read-port signals of the pulse-counter serial readout receiver.
// The receiver takes the slave view; the driving side (transmitter/host) takes master.
interface pulse_count_rx_if #(
    parameter int unsigned W = 16
);
    logic         serial_in;
    logic         sl_in;
    logic [2:0]   a_in;
    logic         ovf_ch_in;
    logic         ovf_global_in;
    logic         data_valid;
    logic [W-1:0] data_out;
    logic [2:0]   addr_out;
    logic         frame_err;
    logic         addr_err;
    logic [7:0]   frame_cnt;
    logic         ovf_sticky;
    logic [2:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic         rd_ovf;

    modport slave (
        input  serial_in, sl_in, a_in, ovf_ch_in, ovf_global_in, rd_addr,
        output data_valid, data_out, addr_out, frame_err, addr_err, frame_cnt, ovf_sticky,
               rd_data, rd_ovf
    );

    modport master (
        output serial_in, sl_in, a_in, ovf_ch_in, ovf_global_in, rd_addr,
        input  data_valid, data_out, addr_out, frame_err, addr_err, frame_cnt, ovf_sticky,
               rd_data, rd_ovf
    );
endinterface

// File: rtl/pulse_count_rx.sv
// Deserializes the pulse-counter readout stream (MSB first, framed by sl_in) and stores
// each completed word in a per-channel register bank with a combinational read port.
module pulse_count_rx #(
    parameter int unsigned W   = 16,
    parameter int unsigned NCH = 5
) (
    input  logic            clk,
    input  logic            reset,
    pulse_count_rx_if.slave bus
);

    localparam int unsigned CntW = $clog2(W);
    localparam logic [3:0]  NchL = 4'(NCH);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [W-1:0]      shreg_q, shreg_d;
    logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]        addr_lat_q, addr_lat_d;
    logic              ovf_lat_q, ovf_lat_d;
    logic [W-1:0]      data_out_q, data_out_d;
    logic [2:0]        addr_out_q, addr_out_d;
    logic              data_valid_q, data_valid_d;
    logic              frame_err_q, frame_err_d;
    logic              addr_err_q, addr_err_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;
    logic              ovf_sticky_q, ovf_sticky_d;
    logic [W-1:0]      bank_q [NCH];
    logic [W-1:0]      bank_d [NCH];
    logic [NCH-1:0]    bank_ovf_q, bank_ovf_d;

    logic [W-1:0]      word;
    logic              addr_ok;
    logic [W-1:0]      rd_data_c;
    logic              rd_ovf_c;

    // The word completes on the edge that samples its last bit, so it includes serial_in.
    assign word    = {shreg_q[W-2:0], bus.serial_in};
    assign addr_ok = {1'b0, addr_lat_q} < NchL;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        addr_lat_d   = addr_lat_q;
        ovf_lat_d    = ovf_lat_q;
        data_out_d   = data_out_q;
        addr_out_d   = addr_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        addr_err_d   = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        ovf_sticky_d = ovf_sticky_q | bus.ovf_global_in;
        bank_d       = bank_q;
        bank_ovf_d   = bank_ovf_q;

        unique case (state_q)
            StIdle: begin
                if (bus.sl_in) begin
                    state_d    = StShift;
                    addr_lat_d = bus.a_in;
                    ovf_lat_d  = bus.ovf_ch_in;
                    shreg_d    = '0;
                    bit_cnt_d  = '0;
                end
            end
            StShift: begin
                if (bus.sl_in) begin
                    // Early strobe: drop the partial word and restart on the new address.
                    frame_err_d = 1'b1;
                    addr_lat_d  = bus.a_in;
                    ovf_lat_d   = bus.ovf_ch_in;
                    shreg_d     = '0;
                    bit_cnt_d   = '0;
                end else begin
                    shreg_d   = word;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CntW'(W - 1)) begin
                        state_d      = StIdle;
                        data_out_d   = word;
                        addr_out_d   = addr_lat_q;
                        data_valid_d = 1'b1;
                        if (addr_ok) begin
                            for (int i = 0; i < NCH; i++) begin
                                if (addr_lat_q == 3'(i)) begin
                                    bank_d[i]     = word;
                                    bank_ovf_d[i] = ovf_lat_q;
                                end
                            end
                            frame_cnt_d  = frame_cnt_q + 8'd1;
                            ovf_sticky_d = ovf_sticky_d | ovf_lat_q;
                        end else begin
                            addr_err_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            addr_lat_q   <= '0;
            ovf_lat_q    <= 1'b0;
            data_out_q   <= '0;
            addr_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            addr_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
            ovf_sticky_q <= 1'b0;
            bank_ovf_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            addr_lat_q   <= addr_lat_d;
            ovf_lat_q    <= ovf_lat_d;
            data_out_q   <= data_out_d;
            addr_out_q   <= addr_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            addr_err_q   <= addr_err_d;
            frame_cnt_q  <= frame_cnt_d;
            ovf_sticky_q <= ovf_sticky_d;
            bank_ovf_q   <= bank_ovf_d;
            bank_q       <= bank_d;
        end
    end

    always_comb begin
        rd_data_c = '0;
        rd_ovf_c  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (bus.rd_addr == 3'(i)) begin
                rd_data_c = bank_q[i];
                rd_ovf_c  = bank_ovf_q[i];
            end
        end
    end

    assign bus.data_valid = data_valid_q;
    assign bus.data_out   = data_out_q;
    assign bus.addr_out   = addr_out_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.addr_err   = addr_err_q;
    assign bus.frame_cnt  = frame_cnt_q;
    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.rd_data    = rd_data_c;
    assign bus.rd_ovf     = rd_ovf_c;

endmodule

// File: tb/tb_pulse_count_rx.sv
// Bench for pulse_count_rx: a constant frame table, hand-written corner sequences, and
// random frames checked against a transaction-level model of the receive bank.
module tb_pulse_count_rx;

    localparam int W   = 16;
    localparam int NCH = 5;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;
    int   cyc;
    int   n_dv_seen, n_fe_seen, n_dv_exp, n_fe_exp;

    // Reference model: what the bank and status should hold after each completed word.
    logic [W-1:0] exp_bank [8];
    logic         exp_ob   [8];
    int           exp_cnt;
    logic         exp_sticky;

    typedef struct {
        logic [2:0]   addr;
        logic [W-1:0] val;
        logic         ovf;
        logic         exp_ae;
        logic [7:0]   exp_cnt;
        logic [W-1:0] exp_rd;
        logic         exp_rovf;
        logic         exp_sticky;
    } vec_t;

    vec_t vecs [8];

    pulse_count_rx_if #(.W(W)) bus ();

    pulse_count_rx #(.W(W), .NCH(NCH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.data_valid) n_dv_seen <= n_dv_seen + 1;
        if (bus.frame_err)  n_fe_seen <= n_fe_seen + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input int a);
        return (a < NCH) ? exp_bank[a] : '0;
    endfunction

    task automatic cycle(input logic sl, input logic [2:0] a, input logic oc, input logic ser,
                         input logic og);
        bus.sl_in         = sl;
        bus.a_in          = a;
        bus.ovf_ch_in     = oc;
        bus.serial_in     = ser;
        bus.ovf_global_in = og;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            exp_bank[i] = '0;
            exp_ob[i]   = 1'b0;
        end
        exp_cnt    = 0;
        exp_sticky = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_dv"}, bus.data_valid, 0);
        chk({tag, "_fe"}, bus.frame_err, 0);
        chk({tag, "_ae"}, bus.addr_err, 0);
        chk({tag, "_data_out"}, bus.data_out, 0);
        chk({tag, "_addr_out"}, bus.addr_out, 0);
        chk({tag, "_frame_cnt"}, bus.frame_cnt, 0);
        chk({tag, "_sticky"}, bus.ovf_sticky, 0);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            #1;
            chk({tag, "_rd_data"}, bus.rd_data, 0);
            chk({tag, "_rd_ovf"}, bus.rd_ovf, 0);
        end
    endtask

    // Sends one frame. abort_at < W stops after that many bits, leaving the next frame's
    // strobe to abort it; exp_fe says whether this frame's strobe aborts a previous one.
    task automatic send_frame(input logic [2:0] addr, input logic [W-1:0] val, input logic ovf,
                              input int abort_at, input logic exp_fe);
        logic bad;
        bus.rd_addr = addr;
        cycle(1'b1, addr, ovf, ~val[W-1], 1'b0);
        chk("sl_dv", bus.data_valid, 0);
        chk("sl_frame_err", bus.frame_err, exp_fe);
        for (int i = 0; i < W; i++) begin
            if (i == abort_at) return;
            cycle(1'b0, ~addr, ~ovf, val[W-1-i], 1'b0);
            if (i < W - 1) begin
                chk("shift_dv", bus.data_valid, 0);
                chk("shift_ae", bus.addr_err, 0);
            end
        end
        bad = (int'(addr) >= NCH);
        if (!bad) begin
            exp_bank[addr] = val;
            exp_ob[addr]   = ovf;
            exp_cnt        = (exp_cnt + 1) % 256;
            if (ovf) exp_sticky = 1'b1;
        end
        n_dv_exp++;
        chk("done_dv", bus.data_valid, 1);
        chk("done_fe", bus.frame_err, 0);
        chk("done_data_out", bus.data_out, val);
        chk("done_addr_out", bus.addr_out, addr);
        chk("done_addr_err", bus.addr_err, bad);
        chk("done_frame_cnt", bus.frame_cnt, exp_cnt);
        chk("done_sticky", bus.ovf_sticky, exp_sticky);
        chk("done_rd_data", bus.rd_data, exp_rd(addr));
        chk("done_rd_ovf", bus.rd_ovf, bad ? 1'b0 : exp_ob[addr]);
    endtask

    initial begin
        int   t_start;
        int   ab;
        logic prev_abort;
        logic og;

        n_checks = 0; n_errors = 0; cyc = 0;
        n_dv_seen = 0; n_fe_seen = 0; n_dv_exp = 0; n_fe_exp = 0;
        reset = 1'b1;
        bus.sl_in = 1'b0; bus.a_in = '0; bus.ovf_ch_in = 1'b0; bus.serial_in = 1'b0;
        bus.ovf_global_in = 1'b0; bus.rd_addr = '0;
        model_clear();

        vecs[0] = '{3'd2, 16'hA5C3, 1'b0, 1'b0, 8'd1, 16'hA5C3, 1'b0, 1'b0};
        vecs[1] = '{3'd0, 16'h0001, 1'b0, 1'b0, 8'd2, 16'h0001, 1'b0, 1'b0};
        vecs[2] = '{3'd1, 16'h8000, 1'b0, 1'b0, 8'd3, 16'h8000, 1'b0, 1'b0};
        vecs[3] = '{3'd2, 16'hFFFF, 1'b0, 1'b0, 8'd4, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{3'd3, 16'h0001, 1'b0, 1'b0, 8'd5, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{3'd4, 16'h1234, 1'b0, 1'b0, 8'd6, 16'h1234, 1'b0, 1'b0};
        vecs[6] = '{3'd6, 16'h0F0F, 1'b1, 1'b1, 8'd6, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{3'd0, 16'h5555, 1'b1, 1'b0, 8'd7, 16'h5555, 1'b1, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_reset_state("reset");

        // Table: frames sent back to back, each completing W+1 cycles after its strobe.
        for (int i = 0; i < 8; i++) begin
            t_start = cyc;
            send_frame(vecs[i].addr, vecs[i].val, vecs[i].ovf, W, 1'b0);
            chk("vec_latency", 32'(cyc - t_start), 32'(W + 1));
            chk("vec_addr_err", bus.addr_err, vecs[i].exp_ae);
            chk("vec_frame_cnt", bus.frame_cnt, vecs[i].exp_cnt);
            chk("vec_rd_data", bus.rd_data, vecs[i].exp_rd);
            chk("vec_rd_ovf", bus.rd_ovf, vecs[i].exp_rovf);
            chk("vec_sticky", bus.ovf_sticky, vecs[i].exp_sticky);
        end
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("pulse_one_cycle", bus.data_valid, 0);
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            #1;
            chk("tbl_bank", bus.rd_data, exp_rd(a));
        end

        // Abort: early strobe after 8 bits discards the word to address 1.
        do_reset();
        send_frame(3'd1, 16'hBEEF, 1'b1, 8, 1'b0);
        n_fe_exp++;
        send_frame(3'd3, 16'h00FF, 1'b0, W, 1'b1);
        chk("abort_cnt", bus.frame_cnt, 1);
        chk("abort_sticky", bus.ovf_sticky, 0);
        bus.rd_addr = 3'd1; #1;
        chk("abort_bank1", bus.rd_data, 0);
        bus.rd_addr = 3'd3; #1;
        chk("abort_bank3", bus.rd_data, 16'h00FF);

        // Global overflow: one-cycle pulse sets a sticky flag.
        do_reset();
        chk("og_before", bus.ovf_sticky, 0);
        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        chk("og_set", bus.ovf_sticky, 1);
        repeat (3) cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        chk("og_held", bus.ovf_sticky, 1);

        // Frame counter wraps after 256 valid words.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            send_frame(3'(i % NCH), 16'(i * 97), 1'b0, W, 1'b0);
            if (i == 254) chk("wrap_255", bus.frame_cnt, 255);
        end
        chk("wrap_0", bus.frame_cnt, 0);

        // Reset at bit 10 drops the partial word silently.
        send_frame(3'd2, 16'h2222, 1'b1, 10, 1'b0);
        do_reset();
        check_reset_state("midreset");
        send_frame(3'd2, 16'h3C3C, 1'b0, W, 1'b0);
        chk("midreset_cnt", bus.frame_cnt, 1);

        // Random frames, aborts, gaps and global overflow pulses against the model.
        do_reset();
        prev_abort = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (!prev_abort) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    og = ($urandom_range(0, 15) == 0);
                    if (og) exp_sticky = 1'b1;
                    cycle(1'b0, 3'($urandom), 1'($urandom), 1'($urandom), og);
                end
            end
            ab = (k < 79 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, W - 1)) : W;
            send_frame(3'($urandom_range(0, 7)), 16'($urandom), ($urandom_range(0, 7) == 0),
                       ab, prev_abort);
            prev_abort = (ab < W);
            if (prev_abort) n_fe_exp++;
        end
        for (int a = 0; a < 8; a++) begin
            bus.rd_addr = 3'(a);
            #1;
            chk("rand_bank", bus.rd_data, exp_rd(a));
            chk("rand_bank_ovf", bus.rd_ovf, (a < NCH) ? exp_ob[a] : 1'b0);
        end
        chk("rand_cnt", bus.frame_cnt, exp_cnt);

        cycle(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("total_dv_pulses", n_dv_seen, n_dv_exp);
        chk("total_fe_pulses", n_fe_seen, n_fe_exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
